// File: rtl/cdc_pulse_tx_if.sv
// cdc_pulse_tx_if: event strobe, toggle handshake and status bundle for the pulse sender.
interface cdc_pulse_tx_if #(
    parameter int CNT_W = 4
);
    logic             d;
    logic             ack_toggle;
    logic             ovf_clr;
    logic             req_toggle;
    logic             busy;
    logic             sent;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    modport slave (
        input  d, ack_toggle, ovf_clr,
        output req_toggle, busy, sent, pending, overflow
    );

    modport master (
        output d, ack_toggle, ovf_clr,
        input  req_toggle, busy, sent, pending, overflow
    );
endinterface

// File: rtl/cdc_pulse_tx.sv
// cdc_pulse_tx: sending end of a toggle pulse crossing; queues strobe edges and issues
// one request flip per event, each gated on the resynchronised acknowledge toggle.
module cdc_pulse_tx #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk_d,
    input logic            reset_n,
    cdc_pulse_tx_if.slave  bus
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                 state_q, state_d;
    logic                   d_prev_q, d_prev_d;
    logic                   req_q, req_d;
    logic                   sent_q, sent_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   evt, dec, inc, drop, issue, ack_s;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.ack_toggle};
        d_prev_d   = bus.d;
        evt        = bus.d & ~d_prev_q;
        dec        = (state_q == WAIT_ACK) && (ack_s == req_q);
        inc        = evt & (~&pending_q | dec);
        drop       = evt & ~inc;
        // issue looks at the registered count, so a fresh event waits one cycle
        issue      = (state_q == IDLE) && (pending_q != '0);
        pending_d  = pending_q + CNT_W'(inc) - CNT_W'(dec);
        req_d      = req_q ^ issue;
        sent_d     = dec;
        overflow_d = drop | (overflow_q & ~bus.ovf_clr);
        state_d    = issue ? WAIT_ACK : dec ? IDLE : state_q;
    end

    always_ff @(posedge clk_d) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            d_prev_q   <= 1'b0;
            req_q      <= 1'b0;
            sent_q     <= 1'b0;
            overflow_q <= 1'b0;
            pending_q  <= '0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            d_prev_q   <= d_prev_d;
            req_q      <= req_d;
            sent_q     <= sent_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign bus.req_toggle = req_q;
    assign bus.busy       = (state_q == WAIT_ACK);
    assign bus.sent       = sent_q;
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/cdc_pulse_tx.md
Name: cdc_pulse_tx

Overview:
- Sending end of the toggle-based pulse crossing.
- Counts rising edges of a local strobe in its own clock domain and conveys each one as a flip of a request toggle. The far-domain pulse synchroniser turns every flip back into a single-cycle pulse.
- The far domain returns an acknowledge toggle. It is resynchronised here, and a new request flip is issued only after the previous one has been acknowledged. Back-to-back strobes are therefore never merged or lost; they queue in a saturating pending counter.

Parameters:
- CNT_W, 4, width of the pending-event counter (max queued events = 2^CNT_W-1)
- SYNC_STAGES, 2, flops in the ack_toggle synchroniser (legal values >= 2)

Ports:
- clk_d  input  1  block clock (sending domain)
- reset_n  input  1  synchronous active-low reset
- d  input  1  event strobe; each rising edge is one event
- ack_toggle  input  1  acknowledge toggle from far domain (asynchronous to clk_d)
- ovf_clr  input  1  clears the overflow flag
- req_toggle  output  1  request toggle to far domain; one flip per event
- busy  output  1  high while a flip is outstanding (state WAIT_ACK)
- sent  output  1  single-cycle pulse when an outstanding flip is acknowledged
- pending  output  CNT_W  events queued, including the outstanding one
- overflow  output  1  sticky flag: an event was dropped because pending was saturated

Behaviour:
- Reset (reset_n=0 at a clk_d edge) sets the following to 0: d_prev, req_toggle, all ack sync flops, pending, state=IDLE, busy, sent, overflow.
- Reset takes priority over every other action. Reset mid-WAIT_ACK discards the outstanding flip and all queued events. The far side must be reset in the same window; a stale ack_toggle is absorbed because both toggles restart at 0.
- Edge detect: d_prev<=d every cycle. evt = d & ~d_prev, evaluated at the edge.
- Ack sync: SYNC_STAGES-deep shift register of ack_toggle; ack_s is the last stage. No logic is placed on the first stage.
- State IDLE:
  - if pending!=0, flip req_toggle, go to WAIT_ACK, busy<=1.
  - Issue decisions use the registered pending value, so evt is not seen until the following cycle.
- State WAIT_ACK:
  - when ack_s==req_toggle: sent<=1 for one cycle, pending decrements, go to IDLE, busy<=0.
  - The earliest next flip is the cycle after returning to IDLE, so consecutive flips are at least 2 cycles plus the round trip apart.
- Pending arithmetic, applied in the same cycle:
  - inc = evt & (pending != all-ones or dec)
  - dec = ack accepted
  - inc and dec together: pending unchanged.
  - evt while pending is all-ones and no dec: event dropped, pending held, overflow<=1.
- overflow stays set until an ovf_clr=1 cycle. If ovf_clr and a new drop occur in the same cycle, set wins.
- pending never wraps and never underflows. dec only occurs in WAIT_ACK, which implies pending>=1.
- sent is 0 in every cycle other than ack acceptance. req_toggle changes only on IDLE->WAIT_ACK.
- Latency with an immediate far-side ack: rising d sampled at edge 0, pending=1 at edge 0, req flips at edge 1. sent follows SYNC_STAGES cycles after ack_toggle changes.
- The sequence of req_toggle values seen by the far side is always a clean alternation, with exactly one flip per accepted event.

Test Plan:
- Reset, single event: hold reset_n=0 for 3 cycles, release, pulse d high for 1 cycle; testbench loops ack_toggle=req_toggle with 3-cycle delay -> req_toggle flips 0->1 one cycle after detection; busy=1; sent pulses exactly once, 3+SYNC_STAGES cycles later; pending 0->1->0.
- Burst: 5 d pulses, 2 cycles apart, with 10-cycle ack round trip -> pending peaks at 5; exactly 5 req flips and 5 sent pulses, never two flips without an intervening ack; final req_toggle=1.
- Overflow, CNT_W=2, ack held constant: 4 events -> pending saturates at 3, overflow=1 on the 4th event, only one flip issued; then ovf_clr=1 -> overflow=0.
- Simultaneous event and ack: in WAIT_ACK with pending=2, drive evt on the same edge ack is accepted -> pending stays 2, sent=1, next flip in the following cycle.
- Reset mid-operation: pending=3, busy=1, assert reset_n=0 for one cycle -> all outputs 0 next cycle; a late ack_toggle edge causes no sent pulse; a new d event is then handled normally.
- Level input: d held high for 20 cycles -> exactly one event, pending max 1, one req flip.
